// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//
// SPI master transfer engine. It turns the bit-rate clock from the upstream
// clock generator (clk_int, treated as data and edge-detected in the clk
// domain) into sclk / ss_n / mosi and assembles the received miso bits into a
// parallel word. All four CPOL/CPHA modes and MSB/LSB-first ordering are
// supported; the mode, bit order and transmit word are captured at start.
//
// Every clk_int transition (rising or falling) is one sclk half-period. A
// transfer uses one half-period of ss_n-to-sclk setup, 2*DATA_W sclk edges and
// one half-period of sclk-to-ss_n hold.
//
// Ports
//   clk        in   system clock (same clock as the clock generator)
//   reset      in   asynchronous active-low reset
//   clk_int    in   bit-rate clock from the generator, sampled as data
//   CPOL       in   idle sclk level
//   CPHA       in   0: sample on leading edge, 1: sample on trailing edge
//   lsb_first  in   1: LSB shifted first
//   start      in   transfer request, accepted only while idle
//   tx_data    in   word to transmit
//   miso       in   serial receive data
//   sclk       out  SPI serial clock (registered)
//   mosi       out  serial transmit data
//   ss_n       out  active-low slave select
//   busy       out  high from accepted start until done
//   done       out  one-clk pulse on the first idle cycle after a transfer
//   rx_data    out  last received word, held until the next done
// -----------------------------------------------------------------------------
module spi_master_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_int,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              lsb_first,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              ss_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);
    localparam logic [CNT_W-1:0] FIRST_EDGE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                clk_int_q;
    logic                sclk_q, sclk_d;
    logic                ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;

    logic                edge_det;
    logic [CNT_W-1:0]    edge_num;
    logic                edge_odd;
    logic                do_sample;
    logic                do_shift;

    // Both clk_int polarities mark a half-period boundary.
    assign edge_det = clk_int ^ clk_int_q;

    // Number of the sclk edge that the current edge_det would produce.
    assign edge_num = edge_cnt_q + 1'b1;
    assign edge_odd = edge_num[0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clk_int_q  <= 1'b0;
            sclk_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_int_q  <= clk_int;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edge_cnt_d = edge_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        do_sample  = 1'b0;
        do_shift   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // sclk follows the live CPOL so the bus idles at the level the
                // next transfer will start from.
                sclk_d = CPOL;
                ss_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    tx_sr_d    = tx_data;
                    cpol_d     = CPOL;
                    cpha_d     = CPHA;
                    lsb_d      = lsb_first;
                    ss_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    edge_cnt_d = '0;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                // First bit is already on mosi; wait one half-period before
                // the first sclk edge.
                if (edge_det) begin
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                if (edge_det) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_num;

                    // Odd edges are leading, even edges trailing. The shift
                    // edge is the opposite of the sample edge; the very first
                    // (CPHA=1) or very last (CPHA=0) shift slot is skipped so
                    // that exactly DATA_W-1 shifts happen.
                    if (cpha_q) begin
                        do_sample = ~edge_odd;
                        do_shift  = edge_odd && (edge_num != FIRST_EDGE);
                    end else begin
                        do_sample = edge_odd;
                        do_shift  = ~edge_odd && (edge_num != LAST_EDGE);
                    end

                    if (do_sample) begin
                        if (lsb_q) begin
                            rx_sr_d = {miso, rx_sr_q[DATA_W-1:1]};
                        end else begin
                            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                        end
                    end

                    if (do_shift) begin
                        if (lsb_q) begin
                            tx_sr_d = tx_sr_q >> 1;
                        end else begin
                            tx_sr_d = tx_sr_q << 1;
                        end
                    end

                    if (edge_num == LAST_EDGE) begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (edge_det) begin
                    ss_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // mosi is driven straight from the shift register so the first bit is
    // valid from the setup cycle; it is forced low while idle.
    always_comb begin
        mosi = 1'b0;
        if (state_q != S_IDLE) begin
            mosi = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
        end
    end

    assign sclk    = sclk_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
module tb_spi_master_shifter;

    logic       clk;
    logic       reset;
    logic       clk_int;
    logic       CPOL;
    logic       CPHA;
    logic       lsb_first;
    logic       start;
    logic [7:0] tx_data;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    logic       loop_en;
    logic       miso_c;

    int errors = 0;
    int checks = 0;

    spi_master_shifter #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_int   (clk_int),
        .CPOL      (CPOL),
        .CPHA      (CPHA),
        .lsb_first (lsb_first),
        .start     (start),
        .tx_data   (tx_data),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    assign miso = loop_en ? mosi : miso_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit-rate clock toggling once per clk period.
    initial begin
        clk_int = 1'b0;
        forever begin
            @(negedge clk);
            clk_int = ~clk_int;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One full transfer. Starts at a negedge by raising start, monitors the
    // bus every negedge until done, then checks the collected results.
    task automatic run_xfer(input string tag, input logic cpol, input logic cpha,
                            input logic lsb, input logic [7:0] tx, input logic lb,
                            input logic mc, input logic [7:0] exp_rx,
                            input logic chain, input logic mid_start);
        logic [7:0] seen;
        logic [7:0] exp_seq;
        logic       prev_sclk;
        logic       prev_mosi;
        logic       got_done;
        int         rises;
        int         nseen;
        int         bad;
        int         ss_hi;

        CPOL      = cpol;
        CPHA      = cpha;
        lsb_first = lsb;
        tx_data   = tx;
        loop_en   = lb;
        miso_c    = mc;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_start"}, 32'(busy), 32'd1);
        chk({tag, "/ss_n_start"}, 32'(ss_n), 32'd0);

        // Order in which bits are expected on the wire, first bit at MSB.
        for (int i = 0; i < 8; i++) begin
            exp_seq[7-i] = lsb ? tx[i] : tx[7-i];
        end

        prev_sclk = sclk;
        prev_mosi = mosi;
        rises     = 0;
        nseen     = 0;
        bad       = 0;
        ss_hi     = 0;
        seen      = 8'h00;
        got_done  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (mid_start && n == 5) begin
                start   = 1'b1;
                tx_data = 8'h00;
                CPOL    = ~cpol;
            end
            if (mid_start && n == 6) begin
                start = 1'b0;
                CPOL  = cpol;
            end
            if (ss_n) ss_hi++;
            if (sclk != prev_sclk) begin
                if (sclk) rises++;
                if (sclk == (cpol ^ !cpha)) begin
                    seen = {seen[6:0], mosi};
                    nseen++;
                end
            end
            if ((mosi != prev_mosi) &&
                !((sclk != prev_sclk) && (sclk == (cpol ^ cpha)))) begin
                bad++;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
        end

        chk({tag, "/done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "/sclk_rises"}, 32'(rises), 32'd8);
        chk({tag, "/samples"}, 32'(nseen), 32'd8);
        chk({tag, "/mosi_bits"}, 32'(seen), 32'(exp_seq));
        chk({tag, "/mosi_first"}, 32'(seen[7]), 32'(exp_seq[7]));
        chk({tag, "/mosi_bad_change"}, 32'(bad), 32'd0);
        chk({tag, "/ss_n_low"}, 32'(ss_hi), 32'd0);
        chk({tag, "/rx_data"}, 32'(rx_data), 32'(exp_rx));
        chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "/ss_n_at_done"}, 32'(ss_n), 32'd1);
        if (!chain) begin
            @(negedge clk);
            chk({tag, "/done_pulse"}, 32'(done), 32'd0);
            chk({tag, "/sclk_idle"}, 32'(sclk), 32'(cpol));
            chk({tag, "/rx_hold"}, 32'(rx_data), 32'(exp_rx));
        end
    endtask

    initial begin
        int edges;
        logic ps;

        reset     = 1'b0;
        start     = 1'b1;
        CPOL      = 1'b0;
        CPHA      = 1'b0;
        lsb_first = 1'b0;
        tx_data   = 8'hFF;
        loop_en   = 1'b1;
        miso_c    = 1'b0;

        // Reset held with start asserted.
        repeat (5) @(negedge clk);
        chk("reset/ss_n", 32'(ss_n), 32'd1);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/sclk", 32'(sclk), 32'd0);
        chk("reset/mosi", 32'(mosi), 32'd0);
        chk("reset/rx_data", 32'(rx_data), 32'h00);
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_xfer("mode0_A5", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_xfer("mode3_3C", 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_xfer("mode1_lsb_01", 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_xfer("mode0_C3_mid", 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1);
        run_xfer("b2b_5A", 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset after three sclk edges of a 0xFF transfer.
        CPOL      = 1'b0;
        CPHA      = 1'b0;
        lsb_first = 1'b0;
        tx_data   = 8'hFF;
        loop_en   = 1'b0;
        miso_c    = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        ps    = sclk;
        for (int n = 0; n < 100 && edges < 3; n++) begin
            @(negedge clk);
            if (sclk != ps) edges++;
            ps = sclk;
        end
        chk("rst_mid/edges", 32'(edges), 32'd3);
        chk("rst_mid/busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid/ss_n", 32'(ss_n), 32'd1);
        chk("rst_mid/busy", 32'(busy), 32'd0);
        chk("rst_mid/sclk", 32'(sclk), 32'd0);
        chk("rst_mid/rx_data", 32'(rx_data), 32'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_mid/no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid/no_done_after", 32'(done), 32'd0);
        @(negedge clk);

        run_xfer("after_rst_96", 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, 8'h96, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
